// File: rtl/id_scoreboard.sv
// id_scoreboard
//   Decode-stage register scoreboard for late producers (loads, divide/mod,
//   CSR reads). Each architectural register r (1..NREG-1) owns a small
//   counter of outstanding late writes. Decode is held off when a source
//   register has a late write outstanding, or when the destination counter
//   is already at MAX_INFLIGHT. Retire ports report completed late writes.
//   Early (ALU) producers are covered by the bypass network and not tracked.
//
//   Optional feature: define ID_SCOREBOARD_STALL_STAT_EN to build the
//   stall_cycles statistics counter; otherwise stall_cycles reads 0.
//
// Ports:
//   clk           rising-edge clock
//   resetn        asynchronous active-low reset
//   id_valid      decode holds a valid instruction
//   src1_en/addr  first source read enable / register
//   src2_en/addr  second source read enable / register
//   dst_late      instruction writes dst_addr with a late result
//   dst_addr      destination register
//   id_fire       instruction leaves decode this cycle
//   id_ready      no scoreboard hazard (combinational from counters)
//   ret_valid     per-port retire strobe
//   ret_addr      per-port retired register, port i at [i*AW +: AW]
//   sb_err        sticky error: underflow or overflow of a counter
//   stall_cycles  cycles with id_valid & ~id_ready (when feature built)

module id_scoreboard #(
  parameter int NREG         = 32,
  parameter int AW           = 5,
  parameter int MAX_INFLIGHT = 3,
  parameter int NRET         = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               id_valid,
  input  logic               src1_en,
  input  logic [AW-1:0]      src1_addr,
  input  logic               src2_en,
  input  logic [AW-1:0]      src2_addr,
  input  logic               dst_late,
  input  logic [AW-1:0]      dst_addr,
  input  logic               id_fire,
  output logic               id_ready,
  input  logic [NRET-1:0]    ret_valid,
  input  logic [NRET*AW-1:0] ret_addr,
  output logic               sb_err,
  output logic [31:0]        stall_cycles
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

  logic [CW-1:0] cnt     [NREG];
  logic [CW-1:0] cnt_nxt [NREG];
  logic          err_nxt;
  logic [CW-1:0] src1_cnt;
  logic [CW-1:0] src2_cnt;
  logic [CW-1:0] dst_cnt;
  logic          hz1;
  logic          hz2;
  logic          hzd;

  // Counter lookup for the decode fields. The loop starts at register 1, so
  // address 0 (and any address >= NREG) reads as a zero count, which removes
  // the need for separate "addr != 0" qualifiers on the hazards.
  always_comb begin
    src1_cnt = '0;
    src2_cnt = '0;
    dst_cnt  = '0;
    for (int r = 1; r < NREG; r++) begin
      if (src1_addr == AW'(r)) src1_cnt = cnt[r];
      if (src2_addr == AW'(r)) src2_cnt = cnt[r];
      if (dst_addr  == AW'(r)) dst_cnt  = cnt[r];
    end
  end

  assign hz1      = src1_en  & (src1_cnt != '0);
  assign hz2      = src2_en  & (src2_cnt != '0);
  assign hzd      = dst_late & (dst_cnt == CNT_MAX);
  assign id_ready = ~(hz1 | hz2 | hzd);

  // Next-count computation: net change is (issue) - (number of retire hits).
  // Out-of-range results hold/clamp the counter and flag an error.
  always_comb begin
    int inc;
    int dec;
    int net;
    inc        = 0;
    dec        = 0;
    net        = 0;
    err_nxt    = 1'b0;
    cnt_nxt[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      inc = (id_fire && dst_late && (dst_addr == AW'(r))) ? 1 : 0;
      dec = 0;
      for (int i = 0; i < NRET; i++) begin
        if (ret_valid[i] && (ret_addr[i*AW +: AW] == AW'(r))) dec = dec + 1;
      end
      net = int'(cnt[r]) + inc - dec;
      if (net < 0) begin
        cnt_nxt[r] = '0;
        err_nxt    = 1'b1;
      end else if (net > MAX_INFLIGHT) begin
        cnt_nxt[r] = cnt[r];
        err_nxt    = 1'b1;
      end else begin
        cnt_nxt[r] = CW'(net);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
      sb_err <= sb_err | err_nxt;
    end
  end

`ifdef ID_SCOREBOARD_STALL_STAT_EN
  // Free-running stall statistic; wraps modulo 2^32.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cycles <= 32'h0;
    end else if (id_valid && !id_ready) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign stall_cycles = 32'h0;
  // id_valid only feeds the statistics counter.
  logic unused_id_valid;
  assign unused_id_valid = id_valid;
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// Testbench for id_scoreboard: directed scenarios followed by randomized
// traffic, checked against a per-register outstanding-write count model.
module tb_id_scoreboard;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int MAXI = 3;
  localparam int NRET = 2;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               id_valid = 1'b0;
  logic               src1_en = 1'b0;
  logic [AW-1:0]      src1_addr = '0;
  logic               src2_en = 1'b0;
  logic [AW-1:0]      src2_addr = '0;
  logic               dst_late = 1'b0;
  logic [AW-1:0]      dst_addr = '0;
  logic               id_fire = 1'b0;
  logic               id_ready;
  logic [NRET-1:0]    ret_valid = '0;
  logic [NRET*AW-1:0] ret_addr = '0;
  logic               sb_err;
  logic [31:0]        stall_cycles;

  id_scoreboard #(.NREG(NREG), .AW(AW), .MAX_INFLIGHT(MAXI), .NRET(NRET)) dut (
    .clk(clk), .resetn(resetn), .id_valid(id_valid),
    .src1_en(src1_en), .src1_addr(src1_addr),
    .src2_en(src2_en), .src2_addr(src2_addr),
    .dst_late(dst_late), .dst_addr(dst_addr), .id_fire(id_fire),
    .id_ready(id_ready), .ret_valid(ret_valid), .ret_addr(ret_addr),
    .sb_err(sb_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic        err;
    logic [31:0] stall;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  // Reference model: outstanding late writes per register.
  int          mcnt[NREG];
  bit          merr = 1'b0;
  int unsigned mstall = 0;

  // Staged stimulus
  bit               s_valid, s_s1en, s_s2en, s_late, s_allow;
  bit [AW-1:0]      s_s1, s_s2, s_dst;
  bit [NRET-1:0]    s_rv;
  bit [NRET*AW-1:0] s_ra;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic clr();
    s_valid = 0; s_s1en = 0; s_s2en = 0; s_late = 0; s_allow = 0;
    s_s1 = '0; s_s2 = '0; s_dst = '0; s_rv = '0; s_ra = '0;
  endtask

  function automatic bit model_ready();
    bit h1, h2, hd;
    h1 = s_s1en && (s_s1 != 0) && (mcnt[s_s1] != 0);
    h2 = s_s2en && (s_s2 != 0) && (mcnt[s_s2] != 0);
    hd = s_late && (s_dst != 0) && (mcnt[s_dst] == MAXI);
    return !(h1 || h2 || hd);
  endfunction

  task automatic model_update(input bit fire, input bit rdy);
    int delta[NREG];
    int net;
    for (int r = 0; r < NREG; r++) delta[r] = 0;
    if (fire && s_late && s_dst != 0) delta[s_dst] += 1;
    for (int i = 0; i < NRET; i++) begin
      if (s_rv[i] && s_ra[i*AW +: AW] != 0) delta[s_ra[i*AW +: AW]] -= 1;
    end
    for (int r = 1; r < NREG; r++) begin
      net = mcnt[r] + delta[r];
      if (net < 0) begin
        mcnt[r] = 0; merr = 1'b1;
      end else if (net > MAXI) begin
        merr = 1'b1;
      end else begin
        mcnt[r] = net;
      end
    end
`ifdef ID_SCOREBOARD_STALL_STAT_EN
    if (s_valid && !rdy) mstall++;
`endif
  endtask

  // One clock cycle: apply staged stimulus, queue expected outputs, advance model.
  task automatic step();
    bit rdy, fire;
    @(posedge clk); #1;
    rdy  = model_ready();
    fire = s_valid && rdy && s_allow;
    id_valid  = s_valid;  src1_en   = s_s1en; src1_addr = s_s1;
    src2_en   = s_s2en;   src2_addr = s_s2;   dst_late  = s_late;
    dst_addr  = s_dst;    id_fire   = fire;
    ret_valid = s_rv;     ret_addr  = s_ra;
    q.push_back('{ready: rdy, err: merr, stall: mstall});
    model_update(fire, rdy);
  endtask

  // Monitor: compare DUT outputs against queued expectations.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ready", {31'b0, id_ready}, {31'b0, e.ready});
      chk("sb_err", {31'b0, sb_err}, {31'b0, e.err});
      chk("stall_cycles", stall_cycles, e.stall);
    end
  end

  int avail[NREG];
  int rr;

  initial begin
    for (int r = 0; r < NREG; r++) mcnt[r] = 0;
    clr();
    #1;
    chk("reset_ready", {31'b0, id_ready}, 32'd1);
    chk("reset_err", {31'b0, sb_err}, 32'd0);
    chk("reset_stall", stall_cycles, 32'd0);
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    repeat (3) step();

    // Load-use on r5: producer, 4 stalled consumer cycles, retire in the last
    clr(); s_valid = 1; s_late = 1; s_dst = 5; s_allow = 1; step();
    clr(); s_valid = 1; s_s1en = 1; s_s1 = 5; s_allow = 1; step();
    @(negedge clk); chk("loaduse_hazard", {31'b0, id_ready}, 32'd0);
    step(); step();
    s_rv = 2'b01; s_ra = {5'd0, 5'd5}; step();
    s_rv = 2'b00; s_ra = '0; step();
    @(negedge clk); chk("loaduse_release", {31'b0, id_ready}, 32'd1);
`ifdef ID_SCOREBOARD_STALL_STAT_EN
    chk("loaduse_stall_count", stall_cycles, 32'd4);
`endif

    // Saturation on r7
    clr(); s_valid = 1; s_late = 1; s_dst = 7; s_allow = 1;
    repeat (3) step();
    step();
    @(negedge clk); chk("sat_hzd", {31'b0, id_ready}, 32'd0);
    s_rv = 2'b01; s_ra = {5'd0, 5'd7}; step();
    s_rv = 2'b00; s_ra = '0; step();
    @(negedge clk); chk("sat_release", {31'b0, id_ready}, 32'd1);
    clr(); s_rv = 2'b11; s_ra = {5'd7, 5'd7}; step();
    s_rv = 2'b01; s_ra = {5'd0, 5'd7}; step();
    clr(); step();
    @(negedge clk); chk("sat_no_err", {31'b0, sb_err}, 32'd0);

    // Same-cycle issue and retire on r9
    clr(); s_valid = 1; s_late = 1; s_dst = 9; s_allow = 1; step();
    s_rv = 2'b10; s_ra = {5'd9, 5'd0}; step();
    clr(); s_valid = 1; s_s2en = 1; s_s2 = 9; s_allow = 1; step();
    @(negedge clk); chk("same_cycle_hold", {31'b0, id_ready}, 32'd0);
    clr(); s_rv = 2'b10; s_ra = {5'd9, 5'd0}; step();
    clr(); step();

    // Dual retire on r3
    clr(); s_valid = 1; s_late = 1; s_dst = 3; s_allow = 1; step(); step();
    clr(); s_rv = 2'b11; s_ra = {5'd3, 5'd3}; step();
    clr(); s_valid = 1; s_s1en = 1; s_s1 = 3; s_allow = 1; step();
    @(negedge clk); chk("dual_retire_ready", {31'b0, id_ready}, 32'd1);

    // Errors and register 0
    clr(); s_rv = 2'b11; s_ra = {5'd0, 5'd0}; step();
    clr(); step();
    @(negedge clk); chk("r0_no_err", {31'b0, sb_err}, 32'd0);
    clr(); s_valid = 1; s_late = 1; s_dst = 12; s_allow = 1; step(); step();
    clr(); s_valid = 1; s_s1en = 1; s_s1 = 0; s_s2en = 1; s_s2 = 0; step();
    @(negedge clk); chk("src_zero_ready", {31'b0, id_ready}, 32'd1);
    clr(); s_rv = 2'b01; s_ra = {5'd0, 5'd4}; step();
    clr(); s_valid = 1; s_s1en = 1; s_s1 = 4; step();
    @(negedge clk);
    chk("underflow_err", {31'b0, sb_err}, 32'd1);
    chk("underflow_cnt_zero", {31'b0, id_ready}, 32'd1);

    // Asynchronous reset with cnt[12]=2 and sb_err=1
    clr(); s_valid = 1; s_s1en = 1; s_s1 = 12; step();
    @(negedge clk);
    chk("pre_reset_ready", {31'b0, id_ready}, 32'd0);
    chk("pre_reset_err", {31'b0, sb_err}, 32'd1);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("async_ready", {31'b0, id_ready}, 32'd1);
    chk("async_err", {31'b0, sb_err}, 32'd0);
    chk("async_stall", stall_cycles, 32'd0);
    for (int r = 0; r < NREG; r++) mcnt[r] = 0;
    merr = 1'b0; mstall = 0;
    #3 resetn = 1'b1;

    // Randomized traffic with legal retires
    for (int n = 0; n < 400; n++) begin
      clr();
      s_valid = 1'($urandom_range(0, 1));
      s_s1en  = 1'($urandom_range(0, 1));
      s_s1    = AW'($urandom_range(0, 7));
      s_s2en  = 1'($urandom_range(0, 1));
      s_s2    = AW'($urandom_range(0, 7));
      s_late  = ($urandom_range(0, 2) != 0);
      s_dst   = AW'($urandom_range(0, 7));
      s_allow = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < NREG; r++) avail[r] = mcnt[r];
      for (int i = 0; i < NRET; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          rr = $urandom_range(0, 7);
          if (rr == 0 || avail[rr] > 0) begin
            if (rr != 0) avail[rr]--;
            s_rv[i] = 1'b1;
            s_ra[i*AW +: AW] = AW'(rr);
          end
        end
      end
      step();
    end
    clr(); step();

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
